// File: rtl/al_accel_mac_feeder_if.sv
// Operand/handshake bundle between the sample/weight source, the MAC feeder and the MAC.
// slave = feeder side, master = source/observer side.
interface al_accel_mac_feeder_if;
  logic        wgt_valid;
  logic [7:0]  wgt_data;
  logic        wgt_ready;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  mac_wdi_0;
  logic [7:0]  mac_wdi_1;
  logic [7:0]  mac_wdi_2;
  logic [31:0] mac_idi_0;
  logic [31:0] mac_idi_1;
  logic [31:0] mac_idi_2;
  logic [31:0] mac_idi_3;
  logic [31:0] mac_idi_4;
  logic [31:0] mac_idi_5;
  logic [31:0] mac_idi_6;
  logic [31:0] mac_idi_7;
  logic        mac_enb;
  logic        busy;

  modport slave (
    input  wgt_valid, wgt_data, in_valid, in_data, in_last,
    output wgt_ready, in_ready,
    output mac_wdi_0, mac_wdi_1, mac_wdi_2,
    output mac_idi_0, mac_idi_1, mac_idi_2, mac_idi_3,
    output mac_idi_4, mac_idi_5, mac_idi_6, mac_idi_7,
    output mac_enb, busy
  );

  modport master (
    output wgt_valid, wgt_data, in_valid, in_data, in_last,
    input  wgt_ready, in_ready,
    input  mac_wdi_0, mac_wdi_1, mac_wdi_2,
    input  mac_idi_0, mac_idi_1, mac_idi_2, mac_idi_3,
    input  mac_idi_4, mac_idi_5, mac_idi_6, mac_idi_7,
    input  mac_enb, busy
  );
endinterface

// File: rtl/al_accel_mac_feeder.sv
// Weight loader and sliding 8-sample window feeding the accelerator MAC operand buses.
// Build option AL_MAC_FEEDER_PAD_EN: zero-pad and fire a short/partial frame at frame end.
module al_accel_mac_feeder #(
  parameter int STRIDE  = 1,
  parameter int MAC_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  al_accel_mac_feeder_if.slave  bus
);
  localparam int HW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAC_LAT - 1);
  localparam logic [3:0]    STRIDE_C  = 4'(STRIDE);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_FIRE, S_HOLD, S_FLUSH} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    beat_reg, beat_next;
  logic [3:0]    fill_reg, fill_next;
  logic [3:0]    new_reg, new_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic          pend_reg, pend_next;
  logic [7:0]    wdi_reg [3];
  logic [7:0]    wdi_next [3];
  logic [31:0]   win_reg [8];
  logic [31:0]   win_next [8];

  logic          wgt_acc, in_acc, fire_hit, shift_en;
  logic [31:0]   shift_val;

  assign wgt_acc  = bus.wgt_valid & bus.wgt_ready;
  assign in_acc   = bus.in_valid & bus.in_ready;
  // Evaluated against the pre-shift counts: the shift in progress completes the window.
  assign fire_hit = (fill_reg == 4'd7) ||
                    ((fill_reg == 4'd8) && ((new_reg + 4'd1) == STRIDE_C));

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    fill_next  = fill_reg;
    new_next   = new_reg;
    hold_next  = hold_reg;
    pend_next  = pend_reg;
    wdi_next   = wdi_reg;
    win_next   = win_reg;
    shift_en   = 1'b0;
    shift_val  = '0;

    case (state_reg)
      S_IDLE: begin
        if (wgt_acc) begin
          case (beat_reg)
            2'd0:    wdi_next[0] = bus.wgt_data;
            2'd1:    wdi_next[1] = bus.wgt_data;
            default: wdi_next[2] = bus.wgt_data;
          endcase
          if (beat_reg == 2'd2) begin
            beat_next  = 2'd0;
            fill_next  = 4'd0;
            new_next   = 4'd0;
            pend_next  = 1'b0;
            state_next = S_FILL;
          end else begin
            beat_next = beat_reg + 2'd1;
          end
        end
      end
      S_FILL: begin
        if (in_acc) begin
          shift_en  = 1'b1;
          shift_val = bus.in_data;
          if (fire_hit) begin
            state_next = S_FIRE;
            pend_next  = bus.in_last;
          end else if (bus.in_last) begin
            state_next = S_FLUSH;
          end
        end
      end
      S_FIRE: begin
        hold_next  = '0;
        state_next = S_HOLD;
      end
      S_HOLD: begin
        if (hold_reg == HOLD_LAST) begin
          state_next = pend_reg ? S_IDLE : S_FILL;
          pend_next  = 1'b0;
        end else begin
          hold_next = hold_reg + 1'b1;
        end
      end
      S_FLUSH: begin
`ifdef AL_MAC_FEEDER_PAD_EN
        shift_en  = 1'b1;
        shift_val = '0;
        if (fire_hit) begin
          state_next = S_FIRE;
          pend_next  = 1'b1;
        end
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase

    if (shift_en) begin
      for (int i = 0; i < 7; i++) win_next[i] = win_reg[i+1];
      win_next[7] = shift_val;
      fill_next   = (fill_reg == 4'd8) ? 4'd8 : fill_reg + 4'd1;
      new_next    = fire_hit ? 4'd0 : new_reg + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      beat_reg  <= '0;
      fill_reg  <= '0;
      new_reg   <= '0;
      hold_reg  <= '0;
      pend_reg  <= 1'b0;
      for (int i = 0; i < 3; i++) wdi_reg[i] <= '0;
      for (int i = 0; i < 8; i++) win_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      fill_reg  <= fill_next;
      new_reg   <= new_next;
      hold_reg  <= hold_next;
      pend_reg  <= pend_next;
      wdi_reg   <= wdi_next;
      win_reg   <= win_next;
    end
  end

  // Strobes are gated by reset so nothing is offered or fired while reset is held.
  assign bus.wgt_ready = (state_reg == S_IDLE)  & ~reset;
  assign bus.in_ready  = (state_reg == S_FILL)  & ~reset;
  assign bus.mac_enb   = (state_reg == S_FIRE)  & ~reset;
  assign bus.busy      = (state_reg != S_IDLE)  & ~reset;

  assign bus.mac_wdi_0 = wdi_reg[0];
  assign bus.mac_wdi_1 = wdi_reg[1];
  assign bus.mac_wdi_2 = wdi_reg[2];
  assign bus.mac_idi_0 = win_reg[0];
  assign bus.mac_idi_1 = win_reg[1];
  assign bus.mac_idi_2 = win_reg[2];
  assign bus.mac_idi_3 = win_reg[3];
  assign bus.mac_idi_4 = win_reg[4];
  assign bus.mac_idi_5 = win_reg[5];
  assign bus.mac_idi_6 = win_reg[6];
  assign bus.mac_idi_7 = win_reg[7];
endmodule

// File: doc/al_accel_mac_feeder.md
# al_accel_mac_feeder

Stream-side front end for the accelerator MAC. It accepts a 3-beat weight load and a stream of signed 32-bit input samples over valid/ready. It assembles a sliding 8-sample window and drives the MAC operand buses (`mac_wdi_0..2`, `mac_idi_0..7`) plus a one-cycle `mac_enb` strobe. The block is the producer for the MAC's operand/enable interface. It holds the operands stable for the MAC's compute latency before admitting new data.

## Interface
- `STRIDE`, 1: new samples required between successive fires after the first full window; legal range 1..8.
- `MAC_LAT`, 2: cycles after the `mac_enb` pulse during which operands stay frozen; legal range ≥1.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wgt_valid`  in  1  weight beat valid.
- `wgt_data`  in  8  signed weight.
- `wgt_ready`  out  1  weight beat accepted when `wgt_valid & wgt_ready`.
- `in_valid`  in  1  sample valid.
- `in_data`  in  32  signed sample.
- `in_last`  in  1  marks final sample of frame; qualified by handshake.
- `in_ready`  out  1  sample accepted when `in_valid & in_ready`.
- `mac_wdi_0..2`  out  8 each  weight operands, beat order 0,1,2.
- `mac_idi_0..7`  out  32 each  window; `_0` oldest, `_7` newest.
- `mac_enb`  out  1  one-cycle fire strobe to MAC.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE (weight load), FILL, FIRE, HOLD, FLUSH.
- IDLE: `wgt_ready`=1. Beats are written to `wdi_0`, `wdi_1`, `wdi_2` in order; the beat counter is 2 bits. The third accepted beat moves to FILL and clears `fill_cnt` (0..8) and `new_cnt`.
- FILL: `in_ready`=1. On accept, the window shifts toward `_0`, `in_data` is written to `_7`, `fill_cnt` saturates at 8, and `new_cnt` increments.
- Fire condition on the accepting cycle: `fill_cnt` reaches 8 for the first time, or (`fill_cnt`==8 and `new_cnt`==STRIDE). When met, go to FIRE and clear `new_cnt`.
- FIRE: `mac_enb`=1 for exactly one cycle, `in_ready`=0. Then go to HOLD.
- HOLD: `in_ready`=0; counts MAC_LAT cycles. Exit goes to IDLE if a frame end is pending, else to FILL.
- `in_last` accepted in FILL:
  - If the same beat meets the fire condition: fire, then return to IDLE (pending flag).
  - Otherwise: go to FLUSH.
- FLUSH: handling is set by the macro (see Configuration). It exits to IDLE or FIRE. Window and weights persist across IDLE, but `fill_cnt` is reset on frame start.
- All arithmetic is pass-through; no sign extension or modification of data.

## Timing
- Reset (sync, checked each edge) forces the following regardless of state, including mid-HOLD or mid-weight-load:
  - state IDLE;
  - all `mac_*` outputs 0;
  - `mac_enb` 0, `in_ready` 0, `busy` 0;
  - counters 0.
- `wgt_ready` = (state==IDLE) & !`reset`. It is therefore 1 on the first cycle after reset deasserts.
- Outputs are registered. The `mac_idi_*` window updates on the edge after the accept.
- `mac_enb` rises on the edge after the accepting beat that completes a fire. Operands at that point already include that beat.
- Operands are frozen from the `mac_enb` edge through MAC_LAT further cycles: 1+MAC_LAT cycles with `in_ready`=0.
- Minimum fire spacing at STRIDE=1 is STRIDE+1+MAC_LAT cycles.
- `in_valid` held with `in_ready`=0 is not consumed. `in_data` may change only after acceptance.
- Weights offered while not in IDLE are ignored (`wgt_ready`=0).

## Configuration
- `AL_MAC_FEEDER_PAD_EN` defined: FLUSH shifts in zeros, one per cycle, until `fill_cnt`==8 (or, on a full window, until `new_cnt`==STRIDE). It then fires once and returns to IDLE. A frame of N<8 samples therefore fires with 8−N trailing zeros.
- Undefined: FLUSH discards the partial window without firing, goes to IDLE in one cycle, and leaves `mac_idi_*` unchanged.

## Test plan
- Reset 5 cycles, then idle: all `mac_*`=0, `mac_enb`=0, `wgt_ready`=1 from the first post-reset cycle, `in_ready`=0.
- Weights −10, 64, −128, then samples 0, 10, −20, −10, 30, 40, 10, 20 back-to-back:
  - exactly one `mac_enb` pulse, one cycle after the 8th accept;
  - `wdi_0..2`=−10/64/−128 and `idi_0..7` in the order given;
  - `in_ready` low for 1+MAC_LAT cycles.
- STRIDE=1, then continue with 50, 60:
  - two further pulses;
  - the second pulse shows `idi_0`=10 … `idi_7`=50;
  - the third shows `idi_0`=−20 … `idi_7`=60.
- Frame of 5 samples 1..5 with `in_last` on 5:
  - PAD_EN: one fire with `idi_0..7`=1,2,3,4,5,0,0,0;
  - without PAD_EN: no fire, return to IDLE, `busy`=0.
- Random `in_valid` gaps and `wgt_valid` asserted during FILL: sample order is preserved, no samples are lost or duplicated, and weights are unchanged.
- Reset asserted during HOLD: `mac_*`=0 and state IDLE on the next edge; a fresh weight load and 8 samples fire normally.
